// File: rtl/commit_monitor_pkg.sv
// Shared types and helpers for the writeback commit monitor.
package commit_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } commit_state_e;

  // EBREAK: the program marks its own end with this instruction.
  localparam logic [31:0] HALT_INST_DEFAULT = 32'h0010_0073;

  localparam int MAX_XLEN = 64;

  // Rotate left by one within the low 'width' bits; bits above width are cleared.
  function automatic logic [MAX_XLEN-1:0] rotl1(input logic [MAX_XLEN-1:0] v,
                                                input int unsigned width);
    logic [MAX_XLEN-1:0] mask;
    mask = (width >= MAX_XLEN) ? '1 : ((MAX_XLEN'(1) << width) - MAX_XLEN'(1));
    return ((v << 1) | MAX_XLEN'(v[6'(width - 1)])) & mask;
  endfunction

endpackage

// File: rtl/commit_monitor_shadow_regfile.sv
// Shadow architectural register file: multi-port write, highest port wins, x0 hardwired.
module shadow_regfile #(
  parameter int NUM_WB_PORTS = 1,
  parameter int XLEN         = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WB_PORTS-1:0]      we,
  input  logic [NUM_WB_PORTS*5-1:0]    rd,
  input  logic [NUM_WB_PORTS*XLEN-1:0] data,
  input  logic [4:0]                   addr,
  output logic [XLEN-1:0]              rdata
);

  logic [XLEN-1:0] regs [0:31];

  // Later loop iterations override earlier ones, so the highest-index port wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (we[p] && (rd[p*5 +: 5] != 5'd0))
          regs[rd[p*5 +: 5]] <= data[p*XLEN +: XLEN];
      end
    end
  end

  assign rdata = (addr == 5'd0) ? '0 : regs[addr];

endmodule

// File: rtl/commit_monitor.sv
// Writeback commit monitor: shadow regfile, retirement count, halt drain and timeout.
// Optional commit signature output is built when COMMIT_MON_SIG_EN is defined.
import commit_mon_pkg::*;

module commit_monitor #(
  parameter int          NUM_WB_PORTS   = 1,
  parameter int          XLEN           = 32,
  parameter logic [31:0] HALT_INST      = HALT_INST_DEFAULT,
  parameter int          DRAIN_CYCLES   = 1,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WB_PORTS-1:0]      wb_we,
  input  logic [NUM_WB_PORTS*5-1:0]    wb_rd,
  input  logic [NUM_WB_PORTS*XLEN-1:0] wb_result,
  input  logic [31:0]                  ex_inst,
  input  logic [4:0]                   chk_addr,
  output logic [XLEN-1:0]              chk_data,
  output logic [31:0]                  retire_cnt,
  output logic                         done,
  output logic                         timeout,
  output logic                         collision,
`ifdef COMMIT_MON_SIG_EN
  output logic [XLEN-1:0]              signature,
`endif
  output commit_state_e                state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic [CW-1:0]           cycle_cnt;
  logic [DW-1:0]           drain_cnt;
  logic                    active;
  logic [NUM_WB_PORTS-1:0] acc;
  logic [31:0]             n_acc;
  logic                    coll;
  logic                    halt;
  logic                    timeout_hit;
  logic                    drain_last;

  assign active      = (state == ST_RUN) || (state == ST_DRAIN);
  assign halt        = (ex_inst == HALT_INST);
  assign timeout_hit = (32'(cycle_cnt) == 32'(TIMEOUT_CYCLES - 1));
  assign drain_last  = ((32'(drain_cnt) + 32'd1) >= 32'(DRAIN_CYCLES));

  // Accepted ports gate every side effect: regfile, counters, collision, signature.
  always_comb begin
    acc   = '0;
    n_acc = '0;
    coll  = 1'b0;
    for (int p = 0; p < NUM_WB_PORTS; p++)
      acc[p] = active && wb_we[p] && (wb_rd[p*5 +: 5] != 5'd0);
    for (int p = 0; p < NUM_WB_PORTS; p++)
      if (acc[p]) n_acc = n_acc + 32'd1;
    for (int p = 0; p < NUM_WB_PORTS; p++)
      for (int q = p + 1; q < NUM_WB_PORTS; q++)
        if (acc[p] && acc[q] && (wb_rd[p*5 +: 5] == wb_rd[q*5 +: 5]))
          coll = 1'b1;
  end

  shadow_regfile #(
    .NUM_WB_PORTS(NUM_WB_PORTS),
    .XLEN        (XLEN)
  ) u_regfile (
    .clk  (clk),
    .reset(reset),
    .we   (acc),
    .rd   (wb_rd),
    .data (wb_result),
    .addr (chk_addr),
    .rdata(chk_data)
  );

  // Timeout is checked before halt/drain completion so it wins a same-cycle tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      cycle_cnt  <= '0;
      drain_cnt  <= '0;
      retire_cnt <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      collision  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (timeout_hit) begin
            state   <= ST_TIMEOUT;
            timeout <= 1'b1;
          end else if (halt) begin
            if (DRAIN_CYCLES == 0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (timeout_hit) begin
            state   <= ST_TIMEOUT;
            timeout <= 1'b1;
          end else if (drain_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: ;
      endcase

      if (active) begin
        if (cycle_cnt != CW'(TIMEOUT_CYCLES))
          cycle_cnt <= cycle_cnt + CW'(1);
        retire_cnt <= retire_cnt + n_acc;
        if (coll) collision <= 1'b1;
      end
    end
  end

`ifdef COMMIT_MON_SIG_EN
  logic [XLEN-1:0] sig_next;

  always_comb begin
    sig_next = signature;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (acc[p])
        sig_next = XLEN'(rotl1(MAX_XLEN'(sig_next), XLEN))
                 ^ wb_result[p*XLEN +: XLEN]
                 ^ XLEN'(wb_rd[p*5 +: 5]);
    end
  end

  // acc is empty outside RUN/DRAIN, so the signature freezes in the terminal states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) signature <= '0;
    else       signature <= sig_next;
  end
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: program run, x0 drop, collision, reset, timeout.
module tb_commit_monitor;
  import commit_mon_pkg::*;

  localparam int          NP   = 2;
  localparam int          XL   = 32;
  localparam logic [31:0] HALT = 32'h0010_0073;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NP-1:0]    wb_we;
  logic [NP*5-1:0]  wb_rd;
  logic [NP*XL-1:0] wb_result;
  logic [31:0]      ex_inst;
  logic [4:0]       chk_addr;
  logic [XL-1:0]    chk_data;
  logic [31:0]      retire_cnt;
  logic             done;
  logic             timeout;
  logic             collision;
  commit_state_e    state;
`ifdef COMMIT_MON_SIG_EN
  logic [XL-1:0]    signature;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  commit_monitor #(
    .NUM_WB_PORTS  (NP),
    .XLEN          (XL),
    .HALT_INST     (HALT),
    .DRAIN_CYCLES  (1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_result (wb_result),
    .ex_inst   (ex_inst),
    .chk_addr  (chk_addr),
    .chk_data  (chk_data),
    .retire_cnt(retire_cnt),
    .done      (done),
    .timeout   (timeout),
    .collision (collision),
`ifdef COMMIT_MON_SIG_EN
    .signature (signature),
`endif
    .state     (state)
  );

  // clock
  always #10 clk = ~clk;

  // driver tasks
  task automatic idle();
    wb_we     = '0;
    wb_rd     = '0;
    wb_result = '0;
    ex_inst   = '0;
  endtask

  task automatic put(input int p, input logic [4:0] rd, input logic [31:0] val);
    wb_we[p]            = 1'b1;
    wb_rd[p*5 +: 5]     = rd;
    wb_result[p*XL +: XL] = val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // checkers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    chk_addr = a;
    #1;
    chk(tag, chk_data, exp);
  endtask

  // x1=5, x2=7, x3=12, x4=1, EBREAK, one drain write, then a write after done.
  task automatic run_program(input string pfx);
    idle(); put(0, 5'd1, 32'd5); step();
`ifdef COMMIT_MON_SIG_EN
    chk({pfx, "_sig1"}, signature, 32'h4);
`endif
    idle(); put(0, 5'd2, 32'd7); step();
`ifdef COMMIT_MON_SIG_EN
    chk({pfx, "_sig2"}, signature, 32'hD);
`endif
    idle(); put(0, 5'd3, 32'd12); step();
    idle(); put(0, 5'd4, 32'd1); step();
    chk({pfx, "_retire4"}, retire_cnt, 32'd4);
    idle(); ex_inst = HALT; step();
    chk({pfx, "_done_in_drain"}, {31'd0, done}, 32'd0);
    chk({pfx, "_state_drain"}, 32'(state), 32'(ST_DRAIN));
    idle(); put(1, 5'd6, 32'h66); step();
    chk({pfx, "_done"}, {31'd0, done}, 32'd1);
    chk({pfx, "_state_done"}, 32'(state), 32'(ST_DONE));
    chk({pfx, "_retire_drain"}, retire_cnt, 32'd5);
    idle(); put(0, 5'd7, 32'h77); ex_inst = HALT; step();
    idle();
    chk({pfx, "_retire_frozen"}, retire_cnt, 32'd5);
    chk({pfx, "_timeout"}, {31'd0, timeout}, 32'd0);
    rd_reg({pfx, "_x1"}, 5'd1, 32'd5);
    rd_reg({pfx, "_x2"}, 5'd2, 32'd7);
    rd_reg({pfx, "_x3"}, 5'd3, 32'd12);
    rd_reg({pfx, "_x4"}, 5'd4, 32'd1);
    rd_reg({pfx, "_x6"}, 5'd6, 32'h66);
    rd_reg({pfx, "_x7_ignored"}, 5'd7, 32'd0);
  endtask

  initial begin
    idle();
    chk_addr = '0;
    reset    = 1'b1;
    step(); step();
    reset = 1'b0;

    // reset state
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_collision", {31'd0, collision}, 32'd0);
    chk("rst_state", 32'(state), 32'(ST_RUN));
    rd_reg("rst_x1", 5'd1, 32'd0);

    run_program("p1");

    // asynchronous reset clears everything without a clock edge
    reset = 1'b1;
    #1;
    rd_reg("areset_x1", 5'd1, 32'd0);
    chk("areset_retire", retire_cnt, 32'd0);
    chk("areset_done", {31'd0, done}, 32'd0);
    chk("areset_state", 32'(state), 32'(ST_RUN));
    @(posedge clk); #1;
    reset = 1'b0;

    // x0 write dropped
    idle(); put(0, 5'd0, 32'hDEAD_BEEF); step();
    rd_reg("x0_zero", 5'd0, 32'd0);
    chk("x0_retire", retire_cnt, 32'd0);

    // same rd on both ports: port 1 wins
    idle(); put(0, 5'd5, 32'h11); put(1, 5'd5, 32'h22); step();
    rd_reg("coll_x5", 5'd5, 32'h22);
    chk("coll_flag", {31'd0, collision}, 32'd1);
    chk("coll_retire", retire_cnt, 32'd2);

    idle(); put(0, 5'd1, 32'd5); step();
    idle();
    rd_reg("mid_x1", 5'd1, 32'd5);
    chk("mid_retire", retire_cnt, 32'd3);

    // reset mid-run, then rerun the program
    reset = 1'b1;
    #1;
    rd_reg("mid_rst_x1", 5'd1, 32'd0);
    rd_reg("mid_rst_x5", 5'd5, 32'd0);
    chk("mid_rst_retire", retire_cnt, 32'd0);
    chk("mid_rst_collision", {31'd0, collision}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_program("p2");

    // runaway program: timeout after the 16th edge
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    repeat (15) step();
    chk("to_not_yet", {31'd0, timeout}, 32'd0);
    chk("to_state_run", 32'(state), 32'(ST_RUN));
    idle(); put(0, 5'd8, 32'h88); step();
    chk("to_flag", {31'd0, timeout}, 32'd1);
    chk("to_state", 32'(state), 32'(ST_TIMEOUT));
    chk("to_retire_last", retire_cnt, 32'd1);
    idle(); put(0, 5'd9, 32'h99); ex_inst = HALT; step();
    idle();
    chk("to_retire_frozen", retire_cnt, 32'd1);
    chk("to_done_low", {31'd0, done}, 32'd0);
    chk("to_sticky", {31'd0, timeout}, 32'd1);
    rd_reg("to_x8", 5'd8, 32'h88);
    rd_reg("to_x9_ignored", 5'd9, 32'd0);

    // report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
